// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the N-way grant arbiter.
package arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        PREEMPT = 2'd2
    } arb_state_e;

    localparam bit MODE_FIXED = 1'b0;
    localparam bit MODE_RR    = 1'b1;

    // One-hot (up to 16 bits) to binary; all-zero input yields 0.
    function automatic logic [3:0] oh2idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of (r & ~mask) starting at ptr, wrapping.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     r_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic [N-1:0]     mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [N-1:0] cand;
    assign cand = r_i & ~mask_i;

    always_comb begin
        logic [IDX_W-1:0] j;
        idx_o   = '0;
        found_o = 1'b0;
        j       = '0;
        for (int i = 0; i < N; i++) begin
            j = IDX_W'((int'(ptr_i) + i) % N);
            if (!found_o && cand[j]) begin
                found_o = 1'b1;
                idx_o   = j;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter with round-robin or fixed priority, same-edge handover and optional
// hold-time preemption. Outputs decode directly from state/holder flops.
module rr_arbiter
    import arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter bit RR_MODE  = MODE_RR,
    parameter int MAX_HOLD = 0,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N-1:0]     r,
    output logic [N-1:0]     g,
    output logic [IDX_W-1:0] g_idx,
    output logic             g_valid,
    output logic             preempt
);

    localparam int HOLD_SAT = (MAX_HOLD > 0) ? MAX_HOLD : 1;
    localparam int HC_W     = $clog2(HOLD_SAT + 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] holder_q, holder_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0]  cnt_q, cnt_d;

    logic [N-1:0]     holder_oh;
    logic [N-1:0]     pick_mask;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             others;
    logic             hold_hit;
    logic             take;

    assign holder_oh = {{(N-1){1'b0}}, 1'b1} << holder_q;
    // Only the decision right after a preemption excludes the previous holder.
    assign pick_mask = (state_q == PREEMPT) ? holder_oh : '0;
    assign others    = |(r & ~holder_oh);
    assign hold_hit  = (MAX_HOLD > 0) && (cnt_q == HC_W'(HOLD_SAT));

    rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .r_i    (r),
        .ptr_i  (ptr_q),
        .mask_i (pick_mask),
        .idx_o  (pick_idx),
        .found_o(pick_found)
    );

    always_comb begin
        state_d  = state_q;
        holder_d = holder_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        take     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) take = 1'b1;
            end
            GRANT: begin
                // Release is checked first so it beats a simultaneous hold limit.
                if (!r[holder_q]) begin
                    if (pick_found) take = 1'b1;
                    else            state_d = IDLE;
                end else if (hold_hit && others) begin
                    state_d = PREEMPT;
                end else if (cnt_q != HC_W'(HOLD_SAT)) begin
                    cnt_d = cnt_q + HC_W'(1);
                end
            end
            PREEMPT: begin
                if (pick_found) take = 1'b1;
                else            state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d  = GRANT;
            holder_d = pick_idx;
            cnt_d    = HC_W'(1);
            if (RR_MODE) ptr_d = (int'(pick_idx) == N - 1) ? '0 : pick_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            holder_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            holder_q <= holder_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign g       = (state_q == GRANT) ? holder_oh : '0;
    assign g_valid = (state_q == GRANT);
    assign g_idx   = IDX_W'(oh2idx(16'(g)));
    assign preempt = (state_q == PREEMPT);

endmodule
